// File: rtl/uart_tx_tick.sv
// Tick-driven UART transmitter: valid/ready word in, LSB-first start/data/stop frame out on tx.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) after the last data bit.
module uart_tx_tick #(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IW = $clog2(DATA_W);
  localparam int SW = $clog2(STOP_BITS + 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_tick: illegal parameter combination");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, ARM, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ARM, START, DATA, STOP} state_t;
`endif

  state_t            state_reg;
  logic [IW-1:0]     idx_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [SW-1:0]     stop_cnt_reg;
  logic              tx_reg;
  logic              ready_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [IW-1:0]     idx_inc;

  // The latched word is never shifted; bits are selected by index, so parity can use the whole word.
  assign idx_inc = idx_reg + 1'b1;

`ifdef UART_TX_PARITY_EN
  logic parity_bit;
  assign parity_bit = (^shift_reg) ^ 1'(PARITY_ODD);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      shift_reg    <= '0;
      stop_cnt_reg <= '0;
      tx_reg       <= 1'b1;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (valid) begin
            shift_reg <= din;
            state_reg <= ARM;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
          end
        end
        // Waiting for a fresh tick so the start bit lasts a full period.
        ARM: begin
          if (en) begin
            tx_reg    <= 1'b0;
            state_reg <= START;
          end
        end
        START: begin
          if (en) begin
            tx_reg    <= shift_reg[0];
            idx_reg   <= '0;
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (en) begin
            if (idx_reg == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              tx_reg    <= parity_bit;
              state_reg <= PARITY;
`else
              tx_reg       <= 1'b1;
              stop_cnt_reg <= '0;
              state_reg    <= STOP;
`endif
            end else begin
              idx_reg <= idx_inc;
              tx_reg  <= shift_reg[idx_inc];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (en) begin
            tx_reg       <= 1'b1;
            stop_cnt_reg <= '0;
            state_reg    <= STOP;
          end
        end
`endif
        STOP: begin
          if (en) begin
            if (stop_cnt_reg == STOP_LAST) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
              ready_reg <= 1'b1;
              busy_reg  <= 1'b0;
            end else begin
              stop_cnt_reg <= stop_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign tx    = tx_reg;
  assign ready = ready_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Directed bench for uart_tx_tick: one 8N1 even-parity instance and one 8N2 odd-parity instance.
module tb_uart_tx_tick;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       valid = 1'b0;
  logic       ready, tx, busy, done;
  logic [7:0] din2 = 8'h00;
  logic       valid2 = 1'b0;
  logic       ready2, tx2, busy2, done2;

  int n_cmp = 0;
  int n_bad = 0;
  int en_div = 12;
  int en_cnt = 0;
  logic last_en = 1'b0;
  int cap[$];

  always #5 clk = ~clk;

  uart_tx_tick #(.DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .valid(valid),
    .ready(ready), .tx(tx), .busy(busy), .done(done)
  );

  uart_tx_tick #(.DATA_W(8), .STOP_BITS(2), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .din(din2), .valid(valid2),
    .ready(ready2), .tx(tx2), .busy(busy2), .done(done2)
  );

  // One clock; en follows the divider (en_div==0 ties it high). Outputs are read 1ns after the edge.
  task automatic step();
    if (en_div == 0) en = 1'b1;
    else en = (en_cnt == en_div - 1);
    @(posedge clk);
    last_en = en;
    if (en_div != 0) en_cnt = (en_cnt + 1) % en_div;
    #1;
  endtask

  // Records tx after every tick until done (or budget runs out); optionally pokes valid mid-frame.
  task automatic capture(input bit sel, input int budget, input int poke_at, output bit got_done);
    got_done = 1'b0;
    cap.delete();
    for (int i = 0; i < budget; i++) begin
      if (!sel) begin
        valid = (i == poke_at);
        if (i == poke_at) din = 8'h00;
      end
      step();
      if (last_en) cap.push_back(int'(sel ? tx2 : tx));
      if (sel ? done2 : done) begin
        got_done = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [15:0] packq(input int q[$]);
    logic [15:0] v = '0;
    for (int i = 0; i < q.size() && i < 16; i++) v[i] = q[i][0];
    return v;
  endfunction

  task automatic test_reset();
    int bad_cycles = 0;
    rst = 1'b1; valid = 1'b1; din = 8'h5A;
    step(); step();
    valid = 1'b0;
    n_cmp++;
    if ({tx, ready, busy, done} !== 4'b1100) begin
      n_bad++;
      $display("FAIL reset_outputs: got tx/ready/busy/done=%b required 1100", {tx, ready, busy, done});
    end
    rst = 1'b0; en_div = 12; en_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if ({tx, ready, busy, done} !== 4'b1100) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles !== 0) begin
      n_bad++;
      $display("FAIL idle_hold: %0d cycles left idle state, required 0", bad_cycles);
    end
    $display("reset/idle: tx=%b ready=%b busy=%b done=%b", tx, ready, busy, done);
  endtask

  task automatic test_frame_a5();
    int exp_q[$];
    bit got;
`ifdef UART_TX_PARITY_EN
    exp_q = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 1};
`else
    exp_q = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif
    din = 8'hA5; valid = 1'b1;
    step();
    valid = 1'b0; din = 8'hFF;
    n_cmp++;
    if ({ready, busy, tx} !== 3'b011) begin
      n_bad++;
      $display("FAIL a5_accept: got ready/busy/tx=%b required 011", {ready, busy, tx});
    end
    capture(1'b0, 400, 30, got);
    n_cmp++;
    if (got !== 1'b1) begin n_bad++; $display("FAIL a5_done: got done=%b required 1", got); end
    n_cmp++;
    if (cap.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL a5_ticks: got %0d ticks required %0d", cap.size(), exp_q.size());
    end
    n_cmp++;
    if (packq(cap) !== packq(exp_q)) begin
      n_bad++;
      $display("FAIL a5_bits: got %h required %h", packq(cap), packq(exp_q));
    end
    n_cmp++;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL a5_ready_at_done: got %b required 1", ready); end
    step();
    n_cmp++;
    if ({done, busy, ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL a5_after_done: got done/busy/ready=%b required 001", {done, busy, ready});
    end
    $display("frame A5: ticks=%0d bits=%h", cap.size(), packq(cap));
  endtask

  task automatic test_back_to_back();
    int exp1[$];
    int exp2[$];
    bit got;
`ifdef UART_TX_PARITY_EN
    exp1 = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    exp2 = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`else
    exp1 = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    exp2 = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
    din2 = 8'h01; valid2 = 1'b1;
    step();
    din2 = 8'hFF;
    n_cmp++;
    if ({ready2, busy2} !== 2'b01) begin
      n_bad++;
      $display("FAIL b2b_accept1: got ready/busy=%b required 01", {ready2, busy2});
    end
    capture(1'b1, 400, -1, got);
    n_cmp++;
    if (got !== 1'b1) begin n_bad++; $display("FAIL b2b_done1: got done=%b required 1", got); end
    n_cmp++;
    if (packq(cap) !== packq(exp1) || cap.size() !== exp1.size()) begin
      n_bad++;
      $display("FAIL b2b_frame1: got %h/%0d ticks required %h/%0d", packq(cap), cap.size(), packq(exp1), exp1.size());
    end
    $display("frame 01: ticks=%0d bits=%h", cap.size(), packq(cap));
    n_cmp++;
    if (ready2 !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_done: got %b required 1", ready2); end
    step();
    valid2 = 1'b0; din2 = 8'h00;
    n_cmp++;
    if ({ready2, busy2, done2} !== 3'b010) begin
      n_bad++;
      $display("FAIL b2b_accept2: got ready/busy/done=%b required 010", {ready2, busy2, done2});
    end
    capture(1'b1, 400, -1, got);
    n_cmp++;
    if (got !== 1'b1) begin n_bad++; $display("FAIL b2b_done2: got done=%b required 1", got); end
    n_cmp++;
    if (packq(cap) !== packq(exp2) || cap.size() !== exp2.size()) begin
      n_bad++;
      $display("FAIL b2b_frame2: got %h/%0d ticks required %h/%0d", packq(cap), cap.size(), packq(exp2), exp2.size());
    end
    $display("frame FF: ticks=%0d bits=%h", cap.size(), packq(cap));
    step();
    n_cmp++;
    if ({ready2, busy2, done2} !== 3'b100) begin
      n_bad++;
      $display("FAIL b2b_idle: got ready/busy/done=%b required 100", {ready2, busy2, done2});
    end
  endtask

  task automatic test_reset_mid_frame();
    int exp_q[$];
    int ticks = 0;
    int stray_done = 0;
    bit got;
`ifdef UART_TX_PARITY_EN
    exp_q = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1};
`else
    exp_q = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
`endif
    din = 8'h3C; valid = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < 200 && ticks < 5; i++) begin
      step();
      if (last_en) ticks++;
    end
    n_cmp++;
    if (ticks !== 5) begin n_bad++; $display("FAIL rstmid_reach_bit3: got %0d ticks required 5", ticks); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({tx, busy, done, ready} !== 4'b1001) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got tx/busy/done/ready=%b required 1001", {tx, busy, done, ready});
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (done || busy) stray_done++;
    end
    n_cmp++;
    if (stray_done !== 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d busy/done cycles required 0", stray_done); end
    $display("reset mid-frame 3C: tx=%b busy=%b", tx, busy);
    din = 8'hC3; valid = 1'b1;
    step();
    valid = 1'b0;
    capture(1'b0, 400, -1, got);
    n_cmp++;
    if (got !== 1'b1 || packq(cap) !== packq(exp_q) || cap.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL rstmid_c3_frame: got %h/%0d ticks done=%b required %h/%0d done=1", packq(cap), cap.size(), got, packq(exp_q), exp_q.size());
    end
    $display("frame C3: ticks=%0d bits=%h", cap.size(), packq(cap));
    step();
  endtask

  task automatic test_en_tied();
    int exp_q[$];
    bit got;
`ifdef UART_TX_PARITY_EN
    exp_q = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1};
`else
    exp_q = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
`endif
    en_div = 0;
    din = 8'h55; valid = 1'b1;
    step();
    valid = 1'b0;
    capture(1'b0, 40, -1, got);
    n_cmp++;
    if (got !== 1'b1) begin n_bad++; $display("FAIL entied_done: got done=%b required 1", got); end
    n_cmp++;
    if (cap.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL entied_cycles: got %0d cycles required %0d", cap.size(), exp_q.size());
    end
    n_cmp++;
    if (packq(cap) !== packq(exp_q)) begin
      n_bad++;
      $display("FAIL entied_bits: got %h required %h", packq(cap), packq(exp_q));
    end
    $display("frame 55 en-tied: cycles=%0d bits=%h", cap.size(), packq(cap));
    en_div = 12; en_cnt = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_reset_mid_frame();
    test_en_tied();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
